// File: rtl/btn_press_classifier_pkg.sv
// Shared types and default timing for the button press classifier.
// Timing defaults assume a 50 MHz clock: 500 ms long press, 100 ms repeat.
package btn_press_classifier_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        IDLE      = 2'd1,
        PRESS     = 2'd2,
        LONG_HOLD = 2'd3
    } state_t;

    localparam int DW_DEFAULT     = 26;
    localparam int LONG_N_DEFAULT = 25_000_000;
    localparam int REP_N_DEFAULT  = 5_000_000;

endpackage

// File: rtl/btn_press_classifier_if.sv
// Button level in, classified press events out.
// The master drives the debounced level; the slave (classifier) drives the events.
interface btn_press_classifier_if;

    logic       sw_limpia;
    logic       tap;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] rep_cnt;

    modport master (
        output sw_limpia,
        input  tap, long_press, repeat_pulse, held, rep_cnt
    );

    modport slave (
        input  sw_limpia,
        output tap, long_press, repeat_pulse, held, rep_cnt
    );

endinterface

// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses into tap, long and auto-repeat events.
// All event outputs are registered; pulses appear the cycle after the deciding sample.
module btn_press_classifier #(
    parameter int DW     = btn_press_classifier_pkg::DW_DEFAULT,
    parameter int LONG_N = btn_press_classifier_pkg::LONG_N_DEFAULT,
    parameter int REP_N  = btn_press_classifier_pkg::REP_N_DEFAULT,
    parameter int REP_EN = 1
) (
    input  logic                          clk_50MHz_i,
    input  logic                          rst_async_la_i,
    btn_press_classifier_if.slave         bus
);

    import btn_press_classifier_pkg::*;

    localparam logic [DW-1:0] LONG_LAST = DW'(LONG_N - 1);
    localparam logic [DW-1:0] REP_LAST  = DW'(REP_N - 1);

    state_t        state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic          tap_reg, tap_next;
    logic          long_reg, long_next;
    logic          rep_reg, rep_next;
    logic          held_reg, held_next;
    logic [7:0]    rep_cnt_reg, rep_cnt_next;

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_reg   <= WAIT_LOW;
            cnt_reg     <= '0;
            tap_reg     <= 1'b0;
            long_reg    <= 1'b0;
            rep_reg     <= 1'b0;
            held_reg    <= 1'b0;
            rep_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            tap_reg     <= tap_next;
            long_reg    <= long_next;
            rep_reg     <= rep_next;
            held_reg    <= held_next;
            rep_cnt_reg <= rep_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        tap_next     = 1'b0;
        long_next    = 1'b0;
        rep_next     = 1'b0;
        held_next    = held_reg;
        rep_cnt_next = rep_cnt_reg;

        case (state_reg)
            // Button may still be down from before reset; wait for a clean release.
            WAIT_LOW: begin
                held_next = 1'b0;
                if (!bus.sw_limpia) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (bus.sw_limpia) begin
                    state_next   = PRESS;
                    cnt_next     = DW'(1);
                    rep_cnt_next = '0;
                end
            end
            PRESS: begin
                if (!bus.sw_limpia) begin
                    tap_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg == LONG_LAST) begin
                    long_next  = 1'b1;
                    held_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = LONG_HOLD;
                end else begin
                    cnt_next = cnt_reg + DW'(1);
                end
            end
            LONG_HOLD: begin
                // Release takes priority over a repeat due on the same sample.
                if (!bus.sw_limpia) begin
                    held_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (REP_EN != 0) begin
                    if (cnt_reg == REP_LAST) begin
                        rep_next = 1'b1;
                        cnt_next = '0;
                        if (rep_cnt_reg != 8'hFF) begin
                            rep_cnt_next = rep_cnt_reg + 8'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + DW'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = WAIT_LOW;
                cnt_next   = '0;
                held_next  = 1'b0;
            end
        endcase
    end

    assign bus.tap          = tap_reg;
    assign bus.long_press   = long_reg;
    assign bus.repeat_pulse = rep_reg;
    assign bus.held         = held_reg;
    assign bus.rep_cnt      = rep_cnt_reg;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed check of the press classifier with LONG_N=8, REP_N=4,
// on one instance with auto-repeat and one without.
module tb_btn_press_classifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    btn_press_classifier_if bus0 ();
    btn_press_classifier_if bus1 ();

    btn_press_classifier #(.DW(8), .LONG_N(8), .REP_N(4), .REP_EN(1)) dut0 (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .bus            (bus0.slave)
    );

    btn_press_classifier #(.DW(8), .LONG_N(8), .REP_N(4), .REP_EN(0)) dut1 (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .bus            (bus1.slave)
    );

    typedef struct {
        logic       sw;
        logic       tap;
        logic       lng;
        logic       rep;
        logic       held;
        logic [7:0] rc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input int n, input logic sw, input logic tap, input logic lng,
                       input logic rep, input logic held, input logic [7:0] rc);
        vec_t v;
        v.sw = sw; v.tap = tap; v.lng = lng; v.rep = rep; v.held = held; v.rc = rc;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic tap, input logic lng,
                        input logic rep, input logic held, input logic [7:0] rc);
        chk($sformatf("%s tap", tag), int'(bus0.tap), int'(tap));
        chk($sformatf("%s long", tag), int'(bus0.long_press), int'(lng));
        chk($sformatf("%s repeat", tag), int'(bus0.repeat_pulse), int'(rep));
        chk($sformatf("%s held", tag), int'(bus0.held), int'(held));
        chk($sformatf("%s rep_cnt", tag), int'(bus0.rep_cnt), int'(rc));
    endtask

    initial begin
        bus0.sw_limpia = 1'b1;
        bus1.sw_limpia = 1'b0;
        rst_n = 1'b0;

        // Phantom-press guard: held button through and after reset.
        add(20, 1, 0, 0, 0, 0, 0);
        add(1,  0, 0, 0, 0, 0, 0);
        add(3,  1, 0, 0, 0, 0, 0);
        add(1,  0, 1, 0, 0, 0, 0);
        // LONG_N-1 samples: tap only.
        add(7,  1, 0, 0, 0, 0, 0);
        add(1,  0, 1, 0, 0, 0, 0);
        // Exactly LONG_N samples: long only, held until the cycle after release.
        add(7,  1, 0, 0, 0, 0, 0);
        add(1,  1, 0, 1, 0, 1, 0);
        add(1,  0, 0, 0, 0, 0, 0);
        // 20 samples: long after 8, repeats after 12, 16, 20.
        add(7,  1, 0, 0, 0, 0, 0);
        add(1,  1, 0, 1, 0, 1, 0);
        add(3,  1, 0, 0, 0, 1, 0);
        add(1,  1, 0, 0, 1, 1, 1);
        add(3,  1, 0, 0, 0, 1, 1);
        add(1,  1, 0, 0, 1, 1, 2);
        add(3,  1, 0, 0, 0, 1, 2);
        add(1,  1, 0, 0, 1, 1, 3);
        add(1,  0, 0, 0, 0, 0, 3);
        // Release on the sample a repeat would fire; rep_cnt cleared at press start.
        add(7,  1, 0, 0, 0, 0, 0);
        add(1,  1, 0, 1, 0, 1, 0);
        add(3,  1, 0, 0, 0, 1, 0);
        add(1,  0, 0, 0, 0, 0, 0);
        // Back-to-back taps three cycles apart, then a single-sample press.
        add(2,  1, 0, 0, 0, 0, 0);
        add(1,  0, 1, 0, 0, 0, 0);
        add(2,  1, 0, 0, 0, 0, 0);
        add(1,  0, 1, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0, 0, 0);
        add(1,  0, 1, 0, 0, 0, 0);
        add(2,  0, 0, 0, 0, 0, 0);

        // Outputs held at zero during reset with the button down.
        repeat (3) tick();
        chk0("in_reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus0.sw_limpia = vecs[i].sw;
            tick();
            chk0($sformatf("vec%0d", i), vecs[i].tap, vecs[i].lng, vecs[i].rep,
                 vecs[i].held, vecs[i].rc);
        end

        // Asynchronous reset while in LONG_HOLD.
        for (int i = 1; i <= 9; i++) begin
            bus0.sw_limpia = 1'b1;
            tick();
            chk($sformatf("hold%0d long", i), int'(bus0.long_press), (i == 8) ? 1 : 0);
        end
        chk("hold held before reset", int'(bus0.held), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk0("async_reset", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk0($sformatf("post_reset%0d", i), 0, 0, 0, 0, 0);
        end
        bus0.sw_limpia = 1'b0;
        tick();
        chk0("release", 0, 0, 0, 0, 0);
        bus0.sw_limpia = 1'b1;
        tick();
        chk0("repress", 0, 0, 0, 0, 0);
        bus0.sw_limpia = 1'b0;
        tick();
        chk0("repress_tap", 1, 0, 0, 0, 0);

        // No auto-repeat instance: 30-sample hold.
        for (int i = 1; i <= 30; i++) begin
            bus1.sw_limpia = 1'b1;
            tick();
            chk($sformatf("norep%0d long", i), int'(bus1.long_press), (i == 8) ? 1 : 0);
            chk($sformatf("norep%0d repeat", i), int'(bus1.repeat_pulse), 0);
            chk($sformatf("norep%0d held", i), int'(bus1.held), (i >= 8) ? 1 : 0);
            chk($sformatf("norep%0d rep_cnt", i), int'(bus1.rep_cnt), 0);
            chk($sformatf("norep%0d tap", i), int'(bus1.tap), 0);
        end
        bus1.sw_limpia = 1'b0;
        tick();
        chk("norep release held", int'(bus1.held), 0);
        chk("norep release tap", int'(bus1.tap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
